// File: rtl/gpio_agent_pkg.sv
// rtl/gpio_agent_pkg.sv - shared opcode, status and FSM state types for gpio_test_agent
// Contents:
//   gpio_op_e     command opcodes (RELEASE, DRIVE, PULSE, WAIT)
//   gpio_status_e response status codes (OK, TIMEOUT, BADCH)
//   gpio_state_e  agent FSM states
package gpio_agent_pkg;

  typedef enum logic [1:0] {
    GPIO_RELEASE = 2'd0,
    GPIO_DRIVE   = 2'd1,
    GPIO_PULSE   = 2'd2,
    GPIO_WAIT    = 2'd3
  } gpio_op_e;

  typedef enum logic [1:0] {
    GPIO_OK      = 2'd0,
    GPIO_TIMEOUT = 2'd1,
    GPIO_BADCH   = 2'd2
  } gpio_status_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } gpio_state_e;

endpackage

// File: rtl/gpio_sync_edge.sv
// rtl/gpio_sync_edge.sv - pad input synchroniser with sticky rise/fall event flags
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   pad_i         raw pad levels (N bits)
//   evt_clr_i     per-channel clear of rise_o/fall_o
//   level_o       pad levels after STAGES flops
//   rise_o/fall_o sticky edge flags, set one cycle after level_o changes
module gpio_sync_edge #(
  parameter int N      = 11,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] pad_i,
  input  logic [N-1:0] evt_clr_i,
  output logic [N-1:0] level_o,
  output logic [N-1:0] rise_o,
  output logic [N-1:0] fall_o
);

  logic [N-1:0] sync_q [STAGES];
  logic [N-1:0] prev_q;

  assign level_o = sync_q[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
      rise_o <= '0;
      fall_o <= '0;
    end else begin
      sync_q[0] <= pad_i;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= level_o;
      // A new edge overrides a simultaneous clear so no event is lost.
      rise_o <= (rise_o & ~evt_clr_i) | (level_o & ~prev_q);
      fall_o <= (fall_o & ~evt_clr_i) | (~level_o & prev_q);
    end
  end

endmodule

// File: rtl/gpio_test_agent.sv
// rtl/gpio_test_agent.sv - N-channel GPIO driver/monitor with command/response handshake
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o          command handshake; ready only when idle
//   cmd_op_i, cmd_ch_i, cmd_val_i    opcode, channel, drive value / awaited level
//   cmd_len_i, cmd_timeout_i         pulse length, wait timeout (0 = forever)
//   rsp_valid_o/rsp_ready_i          response handshake, rsp_status_o status code
//   pad_i, pad_o, pad_oe_o           chip pad input, output value, output enable
//   level_o, rise_o, fall_o          synchronised levels and sticky edge flags
//   evt_clr_i                        per-channel clear for rise_o/fall_o
module gpio_test_agent
  import gpio_agent_pkg::*;
#(
  parameter int N_GPIO      = 11,
  parameter int CH_W        = (N_GPIO > 1) ? $clog2(N_GPIO) : 1,
  parameter int PULSE_W     = 16,
  parameter int TIMEOUT_W   = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [1:0]           cmd_op_i,
  input  logic [CH_W-1:0]      cmd_ch_i,
  input  logic                 cmd_val_i,
  input  logic [PULSE_W-1:0]   cmd_len_i,
  input  logic [TIMEOUT_W-1:0] cmd_timeout_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [1:0]           rsp_status_o,
  input  logic [N_GPIO-1:0]    pad_i,
  output logic [N_GPIO-1:0]    pad_o,
  output logic [N_GPIO-1:0]    pad_oe_o,
  output logic [N_GPIO-1:0]    level_o,
  output logic [N_GPIO-1:0]    rise_o,
  output logic [N_GPIO-1:0]    fall_o,
  input  logic [N_GPIO-1:0]    evt_clr_i
);

  localparam logic [31:0] N_LIMIT = N_GPIO;

  gpio_state_e          state_q;
  gpio_status_e         status_q;
  logic [CH_W-1:0]      ch_q;
  logic                 val_q;
  logic [PULSE_W-1:0]   pulse_cnt_q;
  logic [TIMEOUT_W-1:0] tmo_q;
  logic [TIMEOUT_W-1:0] tcnt_q;

  logic                 ch_bad;
  logic                 wait_match;
  logic [TIMEOUT_W-1:0] tcnt_inc;
  logic [PULSE_W-1:0]   pulse_len;

  gpio_sync_edge #(
    .N      (N_GPIO),
    .STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .pad_i     (pad_i),
    .evt_clr_i (evt_clr_i),
    .level_o   (level_o),
    .rise_o    (rise_o),
    .fall_o    (fall_o)
  );

  assign ch_bad     = {{(32-CH_W){1'b0}}, cmd_ch_i} >= N_LIMIT;
  assign wait_match = (level_o[ch_q] == val_q);
  assign tcnt_inc   = (&tcnt_q) ? tcnt_q : tcnt_q + TIMEOUT_W'(1);
  // A zero length still produces a one-cycle pulse.
  assign pulse_len  = (cmd_len_i == '0) ? PULSE_W'(1) : cmd_len_i;

  assign cmd_ready_o  = (state_q == ST_IDLE);
  assign rsp_valid_o  = (state_q == ST_RESP);
  assign rsp_status_o = status_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      status_q    <= GPIO_OK;
      ch_q        <= '0;
      val_q       <= 1'b0;
      pulse_cnt_q <= '0;
      tmo_q       <= '0;
      tcnt_q      <= '0;
      pad_o       <= '0;
      pad_oe_o    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            ch_q     <= cmd_ch_i;
            val_q    <= cmd_val_i;
            status_q <= GPIO_OK;
            if (ch_bad) begin
              status_q <= GPIO_BADCH;
              state_q  <= ST_RESP;
            end else begin
              case (gpio_op_e'(cmd_op_i))
                GPIO_RELEASE: begin
                  pad_oe_o[cmd_ch_i] <= 1'b0;
                  state_q            <= ST_RESP;
                end
                GPIO_DRIVE: begin
                  pad_o[cmd_ch_i]    <= cmd_val_i;
                  pad_oe_o[cmd_ch_i] <= 1'b1;
                  state_q            <= ST_RESP;
                end
                GPIO_PULSE: begin
                  pad_o[cmd_ch_i]    <= cmd_val_i;
                  pad_oe_o[cmd_ch_i] <= 1'b1;
                  pulse_cnt_q        <= pulse_len;
                  state_q            <= ST_PULSE;
                end
                GPIO_WAIT: begin
                  tmo_q   <= cmd_timeout_i;
                  tcnt_q  <= '0;
                  state_q <= ST_WAIT;
                end
              endcase
            end
          end
        end
        ST_PULSE: begin
          // pulse_cnt_q counts the driven cycles still to go, including this one.
          if (pulse_cnt_q <= PULSE_W'(1)) begin
            pad_oe_o[ch_q] <= 1'b0;
            state_q        <= ST_RESP;
          end else begin
            pulse_cnt_q <= pulse_cnt_q - PULSE_W'(1);
          end
        end
        ST_WAIT: begin
          // Match is tested first so it beats a timeout landing in the same cycle.
          if (wait_match) begin
            state_q <= ST_RESP;
          end else if ((tmo_q != '0) && (tcnt_inc >= tmo_q)) begin
            status_q <= GPIO_TIMEOUT;
            state_q  <= ST_RESP;
          end else begin
            tcnt_q <= tcnt_inc;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_test_agent.sv
// tb/tb_gpio_test_agent.sv - scoreboard bench for gpio_test_agent
module tb_gpio_test_agent;
  import gpio_agent_pkg::*;

  localparam int N  = 11;
  localparam int CW = 4;
  localparam int PW = 16;
  localparam int TW = 24;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [1:0]    cmd_op_i;
  logic [CW-1:0] cmd_ch_i;
  logic          cmd_val_i;
  logic [PW-1:0] cmd_len_i;
  logic [TW-1:0] cmd_timeout_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [1:0]    rsp_status_o;
  logic [N-1:0]  pad_i;
  logic [N-1:0]  pad_o;
  logic [N-1:0]  pad_oe_o;
  logic [N-1:0]  level_o;
  logic [N-1:0]  rise_o;
  logic [N-1:0]  fall_o;
  logic [N-1:0]  evt_clr_i;

  always #5 clk = ~clk;

  gpio_test_agent #(
    .N_GPIO      (N),
    .CH_W        (CW),
    .PULSE_W     (PW),
    .TIMEOUT_W   (TW),
    .SYNC_STAGES (SS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_op_i      (cmd_op_i),
    .cmd_ch_i      (cmd_ch_i),
    .cmd_val_i     (cmd_val_i),
    .cmd_len_i     (cmd_len_i),
    .cmd_timeout_i (cmd_timeout_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_status_o  (rsp_status_o),
    .pad_i         (pad_i),
    .pad_o         (pad_o),
    .pad_oe_o      (pad_oe_o),
    .level_o       (level_o),
    .rise_o        (rise_o),
    .fall_o        (fall_o),
    .evt_clr_i     (evt_clr_i)
  );

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [1:0]   exp_q[$];
  bit           hold_ready = 1'b0;
  logic [N-1:0] m_oe;
  logic [N-1:0] m_o;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: pad ownership per channel and expected status from the command rules.
  function automatic logic [1:0] model(input logic [1:0] op, input int ch, input logic val);
    if (ch >= N) return GPIO_BADCH;
    case (op)
      2'd0: m_oe[ch] = 1'b0;
      2'd1: begin m_o[ch] = val; m_oe[ch] = 1'b1; end
      2'd2: begin m_o[ch] = val; m_oe[ch] = 1'b0; end
      default: return (pad_i[ch] == val) ? GPIO_OK : GPIO_TIMEOUT;
    endcase
    return GPIO_OK;
  endfunction

  // Response monitor: checks every presented response against the scoreboard head.
  initial begin
    rsp_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid_o) begin
        check("rsp_blocks_cmd", cmd_ready_o, 0);
        check("rsp_queue_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) check("rsp_status", rsp_status_o, exp_q[0]);
        if (!hold_ready && $urandom_range(0, 3) != 0) begin
          rsp_ready_i = 1'b1;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
          rsp_ready_i = 1'b0;
        end
      end else begin
        rsp_ready_i = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic wait_ready();
    int w = 0;
    while (!cmd_ready_o && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready_o) check("cmd_ready_timeout", cmd_ready_o, 1);
  endtask

  task automatic send(input logic [1:0] op, input int ch, input logic val,
                      input int len, input int tmo, input logic [1:0] st);
    @(negedge clk);
    wait_ready();
    cmd_op_i      = op;
    cmd_ch_i      = CW'(ch);
    cmd_val_i     = val;
    cmd_len_i     = PW'(len);
    cmd_timeout_i = TW'(tmo);
    cmd_valid_i   = 1'b1;
    exp_q.push_back(st);
    @(posedge clk);
    #1 cmd_valid_i = 1'b0;
  endtask

  task automatic check_pads(input string tag);
    check({tag, "_oe"}, pad_oe_o, m_oe);
    check({tag, "_o"}, pad_o & m_oe, m_o & m_oe);
  endtask

  task automatic do_cmd(input logic [1:0] op, input int ch, input logic val,
                        input int len, input int tmo);
    logic [1:0] st;
    st = model(op, ch, val);
    send(op, ch, val, len, tmo, st);
    wait_ready();
    check_pads("pads_after_cmd");
  endtask

  task automatic pulse_test(input int ch, input logic val, input int len, input int exp_cycles);
    logic [1:0] st;
    int cnt = 0;
    st = model(GPIO_PULSE, ch, val);
    send(GPIO_PULSE, ch, val, len, 0, st);
    for (int i = 0; i < len + 10; i++) begin
      @(negedge clk);
      if (pad_oe_o[ch] && pad_o[ch] == val) cnt++;
      else break;
    end
    check("pulse_len", cnt, exp_cycles);
    wait_ready();
    check_pads("pads_after_pulse");
  endtask

  // Counts cycles spent busy before the response appears.
  task automatic busy_cycles(output int cnt);
    cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rsp_valid_o) break;
      cnt++;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [1:0] st;
    rst_n = 1'b0; cmd_valid_i = 1'b0; cmd_op_i = '0; cmd_ch_i = '0; cmd_val_i = 1'b0;
    cmd_len_i = '0; cmd_timeout_i = '0; pad_i = '0; evt_clr_i = '0;
    m_oe = '0; m_o = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_oe", pad_oe_o, 0);
    check("reset_o", pad_o, 0);
    check("reset_flags", {level_o, rise_o, fall_o}, 0);
    check("reset_rsp_valid", rsp_valid_o, 0);
    check("reset_status", rsp_status_o, GPIO_OK);
    check("reset_cmd_ready", cmd_ready_o, 1);

    // Reset in the middle of a long pulse releases the pad at once.
    send(GPIO_PULSE, 4, 1'b1, 100, 0, GPIO_OK);
    repeat (10) @(negedge clk);
    check("pulse_running", pad_oe_o[4], 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_oe", pad_oe_o, 0);
    check("async_reset_o", pad_o, 0);
    exp_q.delete();
    m_oe = '0; m_o = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_outputs", {pad_oe_o, pad_o, rise_o, fall_o}, 0);
    check("post_reset_cmd_ready", cmd_ready_o, 1);

    // DRIVE then RELEASE while another channel is held.
    do_cmd(GPIO_DRIVE, 1, 1'b0, 0, 0);
    st = model(GPIO_DRIVE, 7, 1'b1);
    send(GPIO_DRIVE, 7, 1'b1, 0, 0, st);
    @(negedge clk);
    check("drive_o7", pad_o[7], 1);
    check("drive_oe7", pad_oe_o[7], 1);
    wait_ready();
    check_pads("pads_after_drive");
    do_cmd(GPIO_RELEASE, 7, 1'b0, 0, 0);

    // Pulse lengths, including zero and a pulse over a driven channel.
    pulse_test(4, 1'b1, 5, 5);
    pulse_test(4, 1'b1, 0, 1);
    pulse_test(5, 1'b0, 1, 1);
    do_cmd(GPIO_DRIVE, 6, 1'b1, 0, 0);
    pulse_test(6, 1'b0, 3, 3);

    // WAIT satisfied by a pad rising mid-wait.
    send(GPIO_WAIT, 8, 1'b1, 0, 1000, GPIO_OK);
    repeat (50) @(negedge clk);
    pad_i[8] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cnt++;
      if (rsp_valid_o) break;
    end
    check("wait_latency_ok", (cnt >= SS && cnt <= SS + 2), 1);
    check("rise8_set", rise_o[8], 1);
    repeat (5) @(negedge clk);
    check("rise8_sticky", rise_o[8], 1);
    evt_clr_i[8] = 1'b1;
    @(negedge clk);
    evt_clr_i[8] = 1'b0;
    check("rise8_cleared", rise_o[8], 0);
    wait_ready();

    // Already matching level, timeout of 20 and of 1.
    st = model(GPIO_WAIT, 8, 1'b1);
    send(GPIO_WAIT, 8, 1'b1, 0, 5, st);
    busy_cycles(cnt);
    check("wait_immediate_cycles", cnt, 1);
    wait_ready();
    st = model(GPIO_WAIT, 0, 1'b1);
    send(GPIO_WAIT, 0, 1'b1, 0, 20, st);
    busy_cycles(cnt);
    check("wait_timeout20_cycles", cnt, 20);
    wait_ready();
    st = model(GPIO_WAIT, 0, 1'b1);
    send(GPIO_WAIT, 0, 1'b1, 0, 1, st);
    busy_cycles(cnt);
    check("wait_timeout1_cycles", cnt, 1);
    wait_ready();

    // Out-of-range channels leave the pads alone.
    do_cmd(GPIO_DRIVE, 11, 1'b1, 0, 0);
    do_cmd(GPIO_PULSE, 15, 1'b1, 4, 0);

    // Backpressure: response held stable while ready is low.
    hold_ready = 1'b1;
    st = model(GPIO_DRIVE, 2, 1'b1);
    send(GPIO_DRIVE, 2, 1'b1, 0, 0, st);
    busy_cycles(cnt);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid_o, 1);
      check("bp_cmd_ready", cmd_ready_o, 0);
    end
    hold_ready = 1'b0;
    wait_ready();
    check_pads("pads_after_bp");

    // Edge set beats a simultaneous clear.
    evt_clr_i[3] = 1'b1;
    pad_i[3] = 1'b1;
    repeat (SS + 1) @(negedge clk);
    check("rise3_set_wins", rise_o[3], 1);
    @(negedge clk);
    check("rise3_cleared", rise_o[3], 0);
    pad_i[3] = 1'b0;
    repeat (SS + 1) @(negedge clk);
    check("fall3_set_wins", fall_o[3], 1);
    evt_clr_i[3] = 1'b0;
    @(negedge clk);
    check("fall3_sticky", fall_o[3], 1);
    evt_clr_i = '1;
    @(negedge clk);
    evt_clr_i = '0;

    // Randomised commands against the reference model.
    for (int k = 0; k < 60; k++) begin
      if (k % 8 == 0) begin
        pad_i = N'($urandom);
        repeat (SS + 2) @(negedge clk);
        check("level_tracks_pad", level_o, pad_i);
      end
      do_cmd(2'($urandom_range(0, 3)), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
             $urandom_range(0, 8), $urandom_range(1, 30));
    end

    wait_ready();
    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
